// File: rtl/fake_n64_pkg.sv
// rtl/fake_n64_pkg.sv - opcodes, constants, state enums and CRC-8 step for the fake N64 controller
package fake_n64_pkg;

  localparam logic [7:0]  CMD_INFO    = 8'h00;
  localparam logic [7:0]  CMD_BUTTONS = 8'h01;
  localparam logic [7:0]  CMD_READ    = 8'h02;
  localparam logic [7:0]  CMD_WRITE   = 8'h03;
  localparam logic [7:0]  CMD_RESET   = 8'hFF;
  localparam logic [7:0]  INFO_ID0    = 8'h05;
  localparam logic [7:0]  INFO_ID1    = 8'h00;
  localparam logic [15:0] ADDR_MASK   = 16'hFFE0;
  localparam logic [7:0]  CRC_POLY    = 8'h85;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR_HI,
    RX_ADDR_LO,
    RX_DATA,
    WAIT_END,
    TX_RESP,
    TX_CRC
  } state_e;

  typedef enum logic [1:0] {
    RESP_INFO,
    RESP_BUTTONS,
    RESP_READ,
    RESP_WRITE
  } resp_e;

  // Whole byte folded in one step: MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fake_n64_cmd_sequencer_if.sv
// rtl/fake_n64_cmd_sequencer_if.sv - rx, pak memory and tx signals of the command sequencer
interface fake_n64_cmd_sequencer_if;

  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_frame_end;
  logic [31:0] buttons;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic        tx_last;
  logic        busy;
  logic        proto_err;

  modport master (
    input  rx_byte_valid, rx_byte, rx_frame_end, buttons, mem_rd_data, tx_byte_ready,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, tx_byte, tx_byte_valid, tx_last,
           busy, proto_err
  );

  modport slave (
    output rx_byte_valid, rx_byte, rx_frame_end, buttons, mem_rd_data, tx_byte_ready,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, tx_byte, tx_byte_valid, tx_last,
           busy, proto_err
  );

endinterface

// File: rtl/n64_crc8.sv
// rtl/n64_crc8.sv - byte-wide CRC-8 (poly 0x85) accumulator shared by rx payload and tx data
module n64_crc8
  import fake_n64_pkg::*;
(
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_next(crc, din);
    end
  end

endmodule

// File: rtl/fake_n64_cmd_sequencer.sv
// rtl/fake_n64_cmd_sequencer.sv - decodes host commands, drives pak memory, schedules response bytes
module fake_n64_cmd_sequencer
  import fake_n64_pkg::*;
#(
  parameter logic [7:0] INFO_STATUS = 8'h01,
  parameter int         PAK_BYTES   = 32
) (
  input  logic                       sample_clk,
  input  logic                       reset_n,
  fake_n64_cmd_sequencer_if.master   bus
);

  localparam logic [5:0] LAST_PAK = 6'(PAK_BYTES - 1);

  state_e      state;
  resp_e       resp;
  logic [7:0]  addr_hi;
  logic [15:0] base;
  logic [5:0]  idx;
  logic [1:0]  rd_phase;
  logic [15:0] mem_addr_q;
  logic        mem_rd_en_q;
  logic        mem_wr_en_q;
  logic [7:0]  mem_wr_data_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic        tx_last_q;
  logic        proto_err_q;

  logic        tx_accept;
  logic        crc_clear;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [7:0]  crc;
  logic [7:0]  resp_byte;

  assign tx_accept = tx_valid_q && bus.tx_byte_ready;

  // CRC restarts on every READ/WRITE; WRITE folds rx payload, READ folds bytes as tx accepts them.
  assign crc_clear = (state == IDLE) && bus.rx_byte_valid &&
                     ((bus.rx_byte == CMD_READ) || (bus.rx_byte == CMD_WRITE));
  assign crc_en    = ((state == RX_DATA) && bus.rx_byte_valid && !bus.rx_frame_end) ||
                     ((state == TX_RESP) && (resp == RESP_READ) && tx_accept);
  assign crc_din   = (state == RX_DATA) ? bus.rx_byte : tx_byte_q;

  n64_crc8 u_crc (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .clear      (crc_clear),
    .en         (crc_en),
    .din        (crc_din),
    .crc        (crc)
  );

  always_comb begin
    resp_byte = 8'h00;
    case (resp)
      RESP_INFO: begin
        case (idx)
          6'd0:    resp_byte = INFO_ID0;
          6'd1:    resp_byte = INFO_ID1;
          default: resp_byte = INFO_STATUS;
        endcase
      end
      RESP_BUTTONS: begin
        case (idx[1:0])
          2'd0:    resp_byte = bus.buttons[31:24];
          2'd1:    resp_byte = bus.buttons[23:16];
          2'd2:    resp_byte = bus.buttons[15:8];
          default: resp_byte = bus.buttons[7:0];
        endcase
      end
      default: resp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      resp          <= RESP_INFO;
      addr_hi       <= 8'h00;
      base          <= 16'h0000;
      idx           <= 6'd0;
      rd_phase      <= 2'd0;
      mem_addr_q    <= 16'h0000;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 8'h00;
      tx_byte_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_byte_valid) begin
            case (bus.rx_byte)
              CMD_INFO, CMD_RESET: begin resp <= RESP_INFO;    state <= WAIT_END;   end
              CMD_BUTTONS:         begin resp <= RESP_BUTTONS; state <= WAIT_END;   end
              CMD_READ:            begin resp <= RESP_READ;    state <= RX_ADDR_HI; end
              CMD_WRITE:           begin resp <= RESP_WRITE;   state <= RX_ADDR_HI; end
              default:             state <= IDLE;
            endcase
          end
        end
        RX_ADDR_HI: begin
          if (bus.rx_frame_end) begin
            proto_err_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.rx_byte_valid) begin
            addr_hi <= bus.rx_byte;
            state   <= RX_ADDR_LO;
          end
        end
        RX_ADDR_LO: begin
          if (bus.rx_frame_end) begin
            proto_err_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.rx_byte_valid) begin
            // Low five bits carry the host's address CRC; they are dropped unchecked.
            base  <= {addr_hi, bus.rx_byte} & ADDR_MASK;
            idx   <= 6'd0;
            state <= (resp == RESP_WRITE) ? RX_DATA : WAIT_END;
          end
        end
        RX_DATA: begin
          if (bus.rx_frame_end) begin
            proto_err_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.rx_byte_valid) begin
            mem_wr_en_q   <= 1'b1;
            mem_wr_data_q <= bus.rx_byte;
            mem_addr_q    <= base + 16'(idx);
            if (idx == LAST_PAK) begin
              idx   <= 6'd0;
              state <= WAIT_END;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        WAIT_END: begin
          if (bus.rx_frame_end) begin
            idx      <= 6'd0;
            rd_phase <= 2'd0;
            state    <= (resp == RESP_WRITE) ? TX_CRC : TX_RESP;
          end
        end
        TX_RESP: begin
          if (bus.rx_byte_valid || bus.rx_frame_end) begin
            proto_err_q <= 1'b1;
          end
          if (resp == RESP_READ) begin
            // Fetch -> wait one cycle for read data -> present; the next fetch waits for acceptance.
            if (tx_valid_q) begin
              if (bus.tx_byte_ready) begin
                tx_valid_q <= 1'b0;
                if (idx == LAST_PAK) begin
                  idx   <= 6'd0;
                  state <= TX_CRC;
                end else begin
                  idx <= idx + 6'd1;
                end
              end
            end else if (rd_phase == 2'd0) begin
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= base + 16'(idx);
              rd_phase    <= 2'd1;
            end else if (rd_phase == 2'd1) begin
              rd_phase <= 2'd2;
            end else begin
              tx_byte_q  <= bus.mem_rd_data;
              tx_valid_q <= 1'b1;
              tx_last_q  <= 1'b0;
              rd_phase   <= 2'd0;
            end
          end else begin
            if (tx_valid_q) begin
              if (bus.tx_byte_ready) begin
                tx_valid_q <= 1'b0;
                tx_last_q  <= 1'b0;
                if (tx_last_q) begin
                  state <= IDLE;
                end else begin
                  idx <= idx + 6'd1;
                end
              end
            end else begin
              tx_byte_q  <= resp_byte;
              tx_valid_q <= 1'b1;
              tx_last_q  <= (idx == ((resp == RESP_INFO) ? 6'd2 : 6'd3));
            end
          end
        end
        TX_CRC: begin
          if (bus.rx_byte_valid || bus.rx_frame_end) begin
            proto_err_q <= 1'b1;
          end
          // One idle cycle on entry lets the final READ byte settle into the CRC register.
          if (!tx_valid_q) begin
            tx_byte_q  <= crc;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b1;
          end else if (bus.tx_byte_ready) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd_en     = mem_rd_en_q;
  assign bus.mem_wr_en     = mem_wr_en_q;
  assign bus.mem_wr_data   = mem_wr_data_q;
  assign bus.tx_byte       = tx_byte_q;
  assign bus.tx_byte_valid = tx_valid_q;
  assign bus.tx_last       = tx_last_q;
  assign bus.busy          = (state != IDLE);
  assign bus.proto_err     = proto_err_q;

endmodule

// File: tb/tb_fake_n64_cmd_sequencer.sv
// tb/tb_fake_n64_cmd_sequencer.sv - directed self-checking bench for fake_n64_cmd_sequencer
module tb_fake_n64_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fake_n64_cmd_sequencer_if bus();

  fake_n64_cmd_sequencer #(.INFO_STATUS(8'h01), .PAK_BYTES(32)) dut (
    .sample_clk (clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;

  logic [7:0]  tx_q[$];
  logic        txl_q[$];
  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];
  logic [7:0]  exp_q[$];

  logic       prev_stall = 1'b0;
  logic [9:0] prev_tx = 10'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h85 : 8'h00);
    end
    return r;
  endfunction

  // Serializer back-pressure: 0 always ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.tx_byte_ready = 1'b1;
      1:       bus.tx_byte_ready = 1'($urandom_range(0, 1));
      default: bus.tx_byte_ready = 1'b0;
    endcase
  end

  // Pak model: byte at address A holds A - 0x20.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= 8'(bus.mem_addr - 16'h0020);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_eq("tx_hold", 32'({bus.tx_byte_valid, bus.tx_last, bus.tx_byte}), 32'(prev_tx));
      prev_stall = bus.tx_byte_valid && !bus.tx_byte_ready;
      prev_tx    = {bus.tx_byte_valid, bus.tx_last, bus.tx_byte};
      if (bus.mem_wr_en) wr_q.push_back({bus.mem_addr, bus.mem_wr_data});
      if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
      if (bus.tx_byte_valid && bus.tx_byte_ready) begin
        tx_q.push_back(bus.tx_byte);
        txl_q.push_back(bus.tx_last);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    tx_q.delete(); txl_q.delete(); rd_q.delete(); wr_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    ready_mode = 0;
    rst_n = 1'b0;
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rx_frame_end = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_byte_valid = 1'b1;
    tick(1);
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic send_end();
    bus.rx_frame_end = 1'b1;
    tick(1);
    bus.rx_frame_end = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("idle_reached", 32'(bus.busy), 32'h0);
    tick(2);
  endtask

  task automatic wait_tx_valid(input int budget);
    int n = 0;
    while (!bus.tx_byte_valid && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("tx_valid_seen", 32'(bus.tx_byte_valid), 32'h1);
  endtask

  task automatic check_tx(input string tag);
    check_eq($sformatf("%s_len", tag), 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(txl_q[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  task automatic run_read(input string tag);
    logic [7:0] c;
    clear_q();
    c = 8'h00;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'(i));
      c = crc_ref(c, 8'(i));
    end
    exp_q.push_back(c);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h20); send_end();
    wait_idle(1000);
    check_tx(tag);
    check_eq($sformatf("%s_rd_cnt", tag), 32'(rd_q.size()), 32'd32);
    for (int i = 0; i < rd_q.size(); i++)
      check_eq($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_q[i]), 32'h0020 + 32'(i));
    check_eq($sformatf("%s_wr_cnt", tag), 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.buttons = 32'h0;
    bus.tx_byte_ready = 1'b0;
    do_reset();
    check_eq("rst_outputs", 32'({bus.busy, bus.tx_byte_valid, bus.tx_last, bus.mem_rd_en,
                                 bus.mem_wr_en, bus.proto_err, bus.tx_byte, bus.mem_wr_data}), 32'h0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);

    // INFO for both 00 and FF
    clear_q();
    exp_q = '{8'h05, 8'h00, 8'h01};
    send_byte(8'h00); send_end();
    wait_idle(100);
    check_tx("info00");
    clear_q();
    exp_q = '{8'h05, 8'h00, 8'h01};
    send_byte(8'hFF); send_end();
    wait_idle(100);
    check_tx("infoFF");

    // BUTTONS with three stalled cycles on the first byte
    clear_q();
    bus.buttons = 32'h8000_1234;
    exp_q = '{8'h80, 8'h00, 8'h12, 8'h34};
    ready_mode = 2;
    send_byte(8'h01); send_end();
    wait_tx_valid(20);
    repeat (3) begin
      check_eq("btn_stall", 32'({bus.tx_byte_valid, bus.tx_last, bus.tx_byte}), 32'h200 | 32'h80);
      tick(1);
    end
    ready_mode = 0;
    wait_idle(100);
    check_tx("buttons");

    // WRITE: 31 zeros then 01 -> CRC 85
    clear_q();
    exp_q = '{8'h85};
    send_byte(8'h03); send_byte(8'h80); send_byte(8'h1F);
    for (int i = 0; i < 32; i++) send_byte((i == 31) ? 8'h01 : 8'h00);
    send_end();
    wait_idle(100);
    check_tx("write");
    check_eq("write_cnt", 32'(wr_q.size()), 32'd32);
    for (int i = 0; i < wr_q.size(); i++)
      check_eq($sformatf("write_%0d", i), 32'(wr_q[i]), {8'h00, 16'h8000 + 16'(i), (i == 31) ? 8'h01 : 8'h00});
    check_eq("write_no_rd", 32'(rd_q.size()), 32'd0);
    check_eq("write_no_err", 32'(bus.proto_err), 32'h0);

    // READ with full ready, then random stalls
    run_read("read");
    ready_mode = 1;
    run_read("read_rand");
    ready_mode = 0;
    tick(2);

    // Unknown command
    clear_q();
    send_byte(8'h7A); send_end();
    tick(5);
    check_eq("unk_no_tx", 32'(tx_q.size()), 32'd0);
    check_eq("unk_state", 32'({bus.busy, bus.proto_err}), 32'h0);

    // Short frame
    clear_q();
    send_byte(8'h02); send_byte(8'h00); send_end();
    tick(5);
    check_eq("short_no_tx", 32'(tx_q.size()), 32'd0);
    check_eq("short_no_mem", 32'(rd_q.size() + wr_q.size()), 32'd0);
    check_eq("short_err", 32'(bus.proto_err), 32'h1);
    check_eq("short_idle", 32'(bus.busy), 32'h0);
    do_reset();
    check_eq("err_cleared", 32'(bus.proto_err), 32'h0);

    // Byte received while responding
    clear_q();
    exp_q = '{8'h05, 8'h00, 8'h01};
    ready_mode = 2;
    send_byte(8'h00); send_end();
    wait_tx_valid(20);
    send_byte(8'h55);
    check_eq("tx_rx_err", 32'(bus.proto_err), 32'h1);
    ready_mode = 0;
    wait_idle(100);
    check_tx("info_err");
    do_reset();

    // Reset in the middle of a READ response
    clear_q();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h20); send_end();
    wait_tx_valid(50);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_eq("midrd_rst_out", 32'({bus.busy, bus.tx_byte_valid, bus.tx_last, bus.mem_rd_en,
                                   bus.mem_wr_en, bus.proto_err, bus.tx_byte, bus.mem_wr_data}), 32'h0);
    check_eq("midrd_rst_addr", 32'(bus.mem_addr), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("midrd_post_idle", 32'({bus.busy, bus.tx_byte_valid}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
